ccd_pixel_capture: RTL and testbench
====================================

Name: ccd_pixel_capture

Overview:
Downstream of the CCD timing generator (ccd_top). Samples the parallel ADC word at each pixel strobe the generator issues and skips the leading dummy pixels. Writes active pixels into a ping-pong line buffer, then raises rd_irq so the CPU can drain the completed line over its read port. The CPU acknowledges with cpu_irq, which releases the bank for reuse.

Parameters:
DATA_W, 12, ADC word width
LINE_LEN, 3648, active pixels stored per line
SKIP, 32, dummy pixels discarded after line_start
ADDR_W, 12, pixel address width; must satisfy 2^ADDR_W >= LINE_LEN

Ports:
clk  in  1  system clock, the single clock domain
rst  in  1  reset; one clock; reset is asynchronous and active-high
line_start  in  1  one-cycle pulse from timing generator at the SH pulse
pix_strobe  in  1  one-cycle pulse per pixel at the settled RS/CP sample point
adc_data  in  DATA_W  ADC output word, valid while pix_strobe is high
cpu_irq  in  1  CPU read-done acknowledge, level; minimum 2 clk high
rd_en  in  1  CPU read request
rd_addr  in  ADDR_W  pixel index in the read bank
rd_data  out  DATA_W  read data
rd_valid  out  1  read data valid strobe
rd_irq  out  1  line ready for CPU
overrun  out  1  sticky: a line completed while the read bank was still held
short_line  out  1  sticky: line_start arrived mid-capture
busy  out  1  high in SKIP or CAPTURE
line_count  out  16  count of lines delivered to the CPU, wraps at 0xFFFF -> 0

Behaviour:
- Reset values: all outputs 0; state IDLE; write bank 0; read bank free; pixel and skip counters 0.
- cpu_irq path:
  - Passes through a 2-flop synchronizer, then a rising-edge detector.
  - An acknowledge takes effect 3 clk after cpu_irq rises.
- State machine:
  - IDLE: on line_start, go to SKIP with skip counter = 0.
  - SKIP: each pix_strobe increments the skip counter. When the counter reaches SKIP, go to CAPTURE. With SKIP=0, go directly to CAPTURE on line_start.
  - CAPTURE: each pix_strobe writes adc_data to write bank at address pix_cnt, then increments pix_cnt. The write of pixel LINE_LEN-1 moves the block to COMMIT on the next cycle.
  - COMMIT (1 cycle), read bank free: swap banks, set rd_irq, increment line_count, go to IDLE.
  - COMMIT (1 cycle), read bank held: set overrun, discard the line without swapping, go to IDLE.
- Latency: rd_irq rises 2 clk after the pix_strobe of the final pixel.
- rd_irq:
  - Holds high until the synchronized cpu_irq rising edge is detected.
  - Clears on the cycle after detection, and the read bank becomes free in that same cycle.
  - A cpu_irq edge while rd_irq is low is ignored.
- line_start during SKIP or CAPTURE:
  - Set short_line, abort the partial line (bank unchanged), restart in SKIP.
  - The pix_strobe on that same cycle counts as the first skip pixel.
- line_start during COMMIT: the commit completes as normal, then the block enters SKIP.
- pix_strobe in IDLE or COMMIT is ignored.
- Read port:
  - rd_en sampled at cycle N gives rd_data and a 1-cycle rd_valid at N+1, always from the current read bank.
  - rd_addr >= LINE_LEN returns 0 with rd_valid still asserted.
  - Reads are legal at any time. With no committed line, they return stale RAM contents.
- Simultaneous events:
  - A bank swap in COMMIT and a same-cycle read: the read uses the pre-swap bank.
  - A write and a read to the same physical bank cannot occur, by construction.
- Sticky flags: overrun and short_line clear only on rst.
- Reset mid-operation: asynchronous return to reset values. RAM contents are not cleared.

Decomposition:
- Shared include ccd_defs.vh holds:
  - state encodings IDLE, SKIP, CAPTURE, COMMIT;
  - default LINE_LEN and SKIP constants, shared with ccd_top so the pixel counts agree.
- Sub-module ccd_line_ram: simple dual-port RAM, depth 2*2^ADDR_W, width DATA_W.
  - Bank select is the address MSB.
  - Synchronous write port and synchronous read port with 1-cycle latency.
- The FSM, counters, synchronizer and flags stay in ccd_pixel_capture.

Test Plan:
Bench parameters LINE_LEN=8, SKIP=2, DATA_W=12 for all scenarios.
- Nominal line: line_start, 10 strobes with adc_data = 0x100+i. Required: rd_irq high 2 clk after strobe 9, line_count=1. Reading addr 0..7 returns 0x102..0x109 with 1-clk latency. Pulsing cpu_irq clears rd_irq 3-4 clk after its rising edge.
- Overrun: two full lines with no cpu_irq. Required: overrun=1, line_count=1, and reads still return line 1 data.
- Ping-pong: line A (0x200+i) acknowledged, then line B (0x300+i). Required: after the second rd_irq, reads return 0x302.. and line_count=2.
- Short line: line_start after 5 capture strobes, then a full line (0x400+i). Required: short_line=1; the full line commits correctly with addr 0 = 0x402.
- Boundary: rd_addr=8 returns 0 with rd_valid=1. Strobes in IDLE change nothing. Asserting rst during CAPTURE gives all outputs 0 within the same cycle (asynchronous). A subsequent line captures normally.

Source files
------------

// File: rtl/ccd_pixel_capture_pkg.sv
// Shared constants for the CCD pixel capture path: FSM encodings and the
// default line geometry that must agree with the timing generator.
package ccd_pixel_capture_pkg;

    localparam int DEFAULT_LINE_LEN = 3648;
    localparam int DEFAULT_SKIP     = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SKIP    = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_COMMIT  = 2'd3;

endpackage

// File: rtl/ccd_pixel_capture_if.sv
// Bundle of the timing-generator, ADC and CPU-side signals of the capture block.
// The slave modport is the capture block; master is whoever drives it.
interface ccd_pixel_capture_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
);
    logic              line_start;
    logic              pix_strobe;
    logic [DATA_W-1:0] adc_data;
    logic              cpu_irq;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_irq;
    logic              overrun;
    logic              short_line;
    logic              busy;
    logic [15:0]       line_count;

    modport master (
        output line_start, pix_strobe, adc_data, cpu_irq, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_irq, overrun, short_line, busy, line_count
    );

    modport slave (
        input  line_start, pix_strobe, adc_data, cpu_irq, rd_en, rd_addr,
        output rd_data, rd_valid, rd_irq, overrun, short_line, busy, line_count
    );

endinterface

// File: rtl/ccd_line_ram.sv
// Ping-pong line buffer: simple dual-port RAM, two banks selected by the
// address MSB, synchronous write and 1-cycle-latency synchronous read.
module ccd_line_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W:0]   i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W:0]   i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/ccd_pixel_capture.sv
// Captures active CCD pixels into a ping-pong line buffer and hands each
// completed line to the CPU via rd_irq / cpu_irq acknowledge.
module ccd_pixel_capture
    import ccd_pixel_capture_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int LINE_LEN = DEFAULT_LINE_LEN,
    parameter int SKIP     = DEFAULT_SKIP,
    parameter int ADDR_W   = 12
) (
    input logic clk,
    input logic rst,
    ccd_pixel_capture_if.slave bus
);

    localparam logic [15:0]       SKIP_CNT = 16'(SKIP);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W:0]   LINE_END = (ADDR_W + 1)'(LINE_LEN);
    localparam state_t            ST_START = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;

    state_t            r_state;
    logic [15:0]       r_skipCnt;
    logic [ADDR_W-1:0] r_pixCnt;
    logic              r_wrBank;
    logic              r_rdIrq;
    logic              r_overrun;
    logic              r_shortLine;
    logic [15:0]       r_lineCount;
    logic              r_irqSync1;
    logic              r_irqSync2;
    logic              r_irqPrev;
    logic              r_rdValid;
    logic              r_rdOor;
    logic [15:0]       w_skipNext;
    logic              w_ackEdge;
    logic              w_wrEn;
    logic [DATA_W-1:0] w_ramData;

    assign w_skipNext = r_skipCnt + 16'd1;
    assign w_ackEdge  = r_irqSync2 & ~r_irqPrev;
    // A line_start on the same cycle as a capture strobe aborts the line, so that write is dropped.
    assign w_wrEn     = (r_state == ST_CAPTURE) && bus.pix_strobe && !bus.line_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_skipCnt   <= '0;
            r_pixCnt    <= '0;
            r_wrBank    <= 1'b0;
            r_overrun   <= 1'b0;
            r_shortLine <= 1'b0;
            r_lineCount <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.line_start) begin
                        r_skipCnt <= '0;
                        r_pixCnt  <= '0;
                        r_state   <= ST_START;
                    end
                end
                ST_SKIP, ST_CAPTURE: begin
                    if (bus.line_start) begin
                        r_shortLine <= 1'b1;
                        r_pixCnt    <= '0;
                        if (SKIP != 0 && bus.pix_strobe) begin
                            r_skipCnt <= 16'd1;
                            r_state   <= (SKIP == 1) ? ST_CAPTURE : ST_SKIP;
                        end else begin
                            r_skipCnt <= '0;
                            r_state   <= ST_START;
                        end
                    end else if (bus.pix_strobe) begin
                        if (r_state == ST_SKIP) begin
                            r_skipCnt <= w_skipNext;
                            if (w_skipNext == SKIP_CNT) begin
                                r_state <= ST_CAPTURE;
                            end
                        end else begin
                            r_pixCnt <= r_pixCnt + 1'b1;
                            if (r_pixCnt == LAST_PIX) begin
                                r_state <= ST_COMMIT;
                            end
                        end
                    end
                end
                default: begin
                    // Read bank still held by the CPU: the fresh line is dropped in place.
                    if (!r_rdIrq) begin
                        r_wrBank    <= ~r_wrBank;
                        r_lineCount <= r_lineCount + 16'd1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_skipCnt <= '0;
                    r_pixCnt  <= '0;
                    r_state   <= bus.line_start ? ST_START : ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irqSync1 <= 1'b0;
            r_irqSync2 <= 1'b0;
            r_irqPrev  <= 1'b0;
            r_rdIrq    <= 1'b0;
        end else begin
            r_irqSync1 <= bus.cpu_irq;
            r_irqSync2 <= r_irqSync1;
            r_irqPrev  <= r_irqSync2;
            if (r_state == ST_COMMIT && !r_rdIrq) begin
                r_rdIrq <= 1'b1;
            end else if (r_rdIrq && w_ackEdge) begin
                r_rdIrq <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdValid <= 1'b0;
            r_rdOor   <= 1'b0;
        end else begin
            r_rdValid <= bus.rd_en;
            r_rdOor   <= bus.rd_en && ({1'b0, bus.rd_addr} >= LINE_END);
        end
    end

    ccd_line_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lineRam (
        .clk      (clk),
        .i_wrEn   (w_wrEn),
        .i_wrAddr ({r_wrBank, r_pixCnt}),
        .i_wrData (bus.adc_data),
        .i_rdEn   (bus.rd_en),
        .i_rdAddr ({~r_wrBank, bus.rd_addr}),
        .o_rdData (w_ramData)
    );

    assign bus.rd_data    = (r_rdValid && !r_rdOor) ? w_ramData : '0;
    assign bus.rd_valid   = r_rdValid;
    assign bus.rd_irq     = r_rdIrq;
    assign bus.overrun    = r_overrun;
    assign bus.short_line = r_shortLine;
    assign bus.busy       = (r_state == ST_SKIP) || (r_state == ST_CAPTURE);
    assign bus.line_count = r_lineCount;

endmodule

// File: tb/tb_ccd_pixel_capture.sv
// Directed bench for ccd_pixel_capture with an 8-pixel line and 2 dummy pixels;
// expected values are hand-computed constants checked by immediate assertions.
module tb_ccd_pixel_capture;

    localparam int DATA_W   = 12;
    localparam int LINE_LEN = 8;
    localparam int SKIP     = 2;
    localparam int ADDR_W   = 4;

    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;

    ccd_pixel_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ccd_pixel_capture #(
        .DATA_W   (DATA_W),
        .LINE_LEN (LINE_LEN),
        .SKIP     (SKIP),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One cycle of timing-generator stimulus; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic ls, input logic ps, input logic [DATA_W-1:0] data);
        bus.line_start = ls;
        bus.pix_strobe = ps;
        bus.adc_data   = data;
        tick();
        bus.line_start = 1'b0;
        bus.pix_strobe = 1'b0;
    endtask

    task automatic sendStrobes(input logic [DATA_W-1:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            applyStimulus(1'b0, 1'b1, base + DATA_W'(i));
        end
    endtask

    task automatic readPixel(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expected);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en   = 1'b0;
        checkOutput({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus.rd_data), 32'(expected));
    endtask

    task automatic ackLine(input string tag);
        bus.cpu_irq = 1'b1;
        tick();
        checkOutput({tag, "_irqHeld1"}, 32'(bus.rd_irq), 32'd1);
        tick();
        checkOutput({tag, "_irqHeld2"}, 32'(bus.rd_irq), 32'd1);
        tick();
        checkOutput({tag, "_irqClear"}, 32'(bus.rd_irq), 32'd0);
        bus.cpu_irq = 1'b0;
        repeat (3) tick();
    endtask

    // Full line: line_start, 2 dummy strobes, 8 pixels; ends with rd_irq timing checks.
    task automatic sendLine(input string tag, input logic [DATA_W-1:0] base, input logic expectIrqRise);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        sendStrobes(base, SKIP + LINE_LEN);
        checkOutput({tag, "_irqAt1"}, 32'(bus.rd_irq), 32'(!expectIrqRise));
        tick();
        checkOutput({tag, "_irqAt2"}, 32'(bus.rd_irq), 32'd1);
        checkOutput({tag, "_busyDone"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst            = 1'b1;
        bus.line_start = 1'b0;
        bus.pix_strobe = 1'b0;
        bus.adc_data   = '0;
        bus.cpu_irq    = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        repeat (2) tick();

        checkOutput("rst_rdIrq", 32'(bus.rd_irq), 32'd0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("rst_shortLine", 32'(bus.short_line), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_lineCount", 32'(bus.line_count), 32'd0);
        checkOutput("rst_rdValid", 32'(bus.rd_valid), 32'd0);
        checkOutput("rst_rdData", 32'(bus.rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Nominal line: pixels 0x102..0x109 land at addresses 0..7.
        sendLine("nom", 12'h100, 1'b1);
        checkOutput("nom_lineCount", 32'(bus.line_count), 32'd1);
        readPixel("nom_a0", 4'd0, 12'h102);
        readPixel("nom_a3", 4'd3, 12'h105);
        readPixel("nom_a7", 4'd7, 12'h109);
        tick();
        checkOutput("nom_validDrop", 32'(bus.rd_valid), 32'd0);
        readPixel("nom_oob8", 4'd8, 12'h000);
        readPixel("nom_oob15", 4'd15, 12'h000);
        ackLine("nom");

        // Ping-pong: line A acknowledged, then line B replaces it in the other bank.
        sendLine("lineA", 12'h200, 1'b1);
        checkOutput("lineA_lineCount", 32'(bus.line_count), 32'd2);
        readPixel("lineA_a0", 4'd0, 12'h202);
        readPixel("lineA_a7", 4'd7, 12'h209);
        ackLine("lineA");
        sendLine("lineB", 12'h300, 1'b1);
        checkOutput("lineB_lineCount", 32'(bus.line_count), 32'd3);
        checkOutput("lineB_overrun", 32'(bus.overrun), 32'd0);
        readPixel("lineB_a0", 4'd0, 12'h302);
        readPixel("lineB_a5", 4'd5, 12'h307);

        // Overrun: a second line completes while line B is still held.
        sendLine("ovr", 12'h500, 1'b0);
        checkOutput("ovr_overrun", 32'(bus.overrun), 32'd1);
        checkOutput("ovr_lineCount", 32'(bus.line_count), 32'd3);
        readPixel("ovr_a0", 4'd0, 12'h302);
        readPixel("ovr_a7", 4'd7, 12'h309);
        ackLine("ovr");
        checkOutput("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Short line: restart after 5 captured pixels, restart strobe counts as a dummy.
        applyStimulus(1'b1, 1'b0, '0);
        sendStrobes(12'h600, SKIP + 5);
        checkOutput("short_busyMid", 32'(bus.busy), 32'd1);
        checkOutput("short_flagBefore", 32'(bus.short_line), 32'd0);
        applyStimulus(1'b1, 1'b1, 12'hFFF);
        checkOutput("short_flag", 32'(bus.short_line), 32'd1);
        checkOutput("short_busyRestart", 32'(bus.busy), 32'd1);
        sendStrobes(12'h401, 1 + LINE_LEN);
        checkOutput("short_irqAt1", 32'(bus.rd_irq), 32'd0);
        tick();
        checkOutput("short_irqAt2", 32'(bus.rd_irq), 32'd1);
        checkOutput("short_lineCount", 32'(bus.line_count), 32'd4);
        readPixel("short_a0", 4'd0, 12'h402);
        readPixel("short_a4", 4'd4, 12'h406);
        readPixel("short_a7", 4'd7, 12'h409);
        ackLine("short");

        // Strobes while idle must not start a capture or disturb the read bank.
        applyStimulus(1'b0, 1'b1, 12'hABC);
        applyStimulus(1'b0, 1'b1, 12'hABD);
        applyStimulus(1'b0, 1'b1, 12'hABE);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("idle_rdIrq", 32'(bus.rd_irq), 32'd0);
        checkOutput("idle_lineCount", 32'(bus.line_count), 32'd4);
        readPixel("idle_a0", 4'd0, 12'h402);

        // Asynchronous reset in the middle of a capture.
        applyStimulus(1'b1, 1'b0, '0);
        sendStrobes(12'h800, SKIP + 2);
        checkOutput("arst_busyBefore", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(bus.busy), 32'd0);
        checkOutput("arst_shortLine", 32'(bus.short_line), 32'd0);
        checkOutput("arst_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("arst_lineCount", 32'(bus.line_count), 32'd0);
        checkOutput("arst_rdIrq", 32'(bus.rd_irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        sendLine("post", 12'h700, 1'b1);
        checkOutput("post_lineCount", 32'(bus.line_count), 32'd1);
        readPixel("post_a0", 4'd0, 12'h702);
        readPixel("post_a7", 4'd7, 12'h709);
        ackLine("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
